// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package seg_pkg;

    localparam int N_DIGITS = 4;

    localparam logic [6:0]          SEG_OFF = 7'b000_0000;
    localparam logic [N_DIGITS-1:0] AN_OFF  = '0;

    // Lowercase forms for b and d keep them distinct from 8 and 0.
    localparam logic [6:0] HEX2SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [4*N_DIGITS-1:0] value;
        logic [N_DIGITS-1:0]   dp;
        logic                  blank_lz;
    } disp_t;

endpackage

// File: rtl/hex2seg.sv
// Combinational hex nibble to active-high seven-segment pattern lookup.
module hex2seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX2SEG[nibble];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver stepped by rising edges of scan_clk.
// Loads are staged in pend and committed to shadow only at the 3-to-0 frame wrap.
module seg_scan
    import seg_pkg::*;
#(
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam logic [6:0] SEG_MASK = {7{SEG_ACT_LOW}};
    localparam logic [3:0] AN_MASK  = {4{AN_ACT_LOW}};

    logic        scan_q;
    logic        tick;
    logic        wrap;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;
    disp_t       pend;
    disp_t       shadow;
    disp_t       incoming;
    disp_t       shadow_nxt;
    logic [3:0]  nonzero;
    logic [3:0]  nibble;
    logic [6:0]  pattern;
    logic [6:0]  seg_lit;
    logic        blank;
    logic [3:0]  an_onehot;

    assign incoming = '{value: value, dp: dp_in, blank_lz: blank_lz};

    assign tick    = scan_clk & ~scan_q;
    assign wrap    = tick && (idx == 2'd3);
    assign idx_nxt = idx + 2'd1;

    // A load in the wrap cycle bypasses pend so it lands in this frame.
    assign shadow_nxt = wrap ? (load ? incoming : pend) : shadow;

    // Outputs are computed for the digit about to be shown, from the shadow it will use.
    always_comb begin
        nonzero = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            nonzero[i] = |shadow_nxt.value[4*i +: 4];
        end
        nibble    = shadow_nxt.value[{idx_nxt, 2'b00} +: 4];
        blank     = shadow_nxt.blank_lz && (idx_nxt != 2'd0) && ((nonzero >> idx_nxt) == 4'd0);
        an_onehot = 4'b0001 << idx_nxt;
    end

    hex2seg u_hex2seg (
        .nibble  (nibble),
        .pattern (pattern)
    );

    assign seg_lit = blank ? SEG_OFF : pattern;

    // NOTE: every register here uses <= so all of them see the same pre-edge idx/tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q     <= 1'b1;
            idx        <= '0;
            pend       <= '0;
            shadow     <= '0;
            seg        <= SEG_OFF ^ SEG_MASK;
            dp         <= SEG_ACT_LOW;
            an         <= AN_OFF ^ AN_MASK;
            frame_done <= 1'b0;
        end else begin
            scan_q     <= scan_clk;
            frame_done <= wrap;
            shadow     <= shadow_nxt;
            if (load) begin
                pend <= incoming;
            end
            if (tick) begin
                idx <= idx_nxt;
                seg <= seg_lit ^ SEG_MASK;
                dp  <= shadow_nxt.dp[idx_nxt] ^ SEG_ACT_LOW;
                an  <= an_onehot ^ AN_MASK;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: table-driven frames plus hand-written reset and load corners.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_clk;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_pass  = 0;
    int n_total = 0;
    logic [1:0] bidx = 2'd0;

    // seg_exp packs the expected active-low pins as {d3, d2, d1, d0}; dp_exp bit i is digit i.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic        blz;
        logic [27:0] seg_exp;
        logic [3:0]  dp_exp;
    } vec_t;

    vec_t vecs [7];

    seg_scan dut (
        .clk        (clk),
        .rst        (rst),
        .scan_clk   (scan_clk),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, " seg"}, seg, 7'h7F);
        check({tag, " dp"}, dp, 1'b1);
        check({tag, " an"}, an, 4'hF);
        check({tag, " frame_done"}, frame_done, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        @(negedge clk);
        load = 1'b1; value = v; dp_in = d; blank_lz = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    // One scan_clk pulse; samples the new digit in the cycle after the tick.
    task automatic do_tick(input bit with_load, input logic [15:0] v, input logic [3:0] d,
                           input logic b);
        logic [3:0] an_exp;
        @(negedge clk);
        scan_clk = 1'b1;
        if (with_load) begin
            load = 1'b1; value = v; dp_in = d; blank_lz = b;
        end
        @(negedge clk);
        scan_clk = 1'b0;
        load     = 1'b0;
        bidx     = bidx + 2'd1;
        an_exp   = ~(4'b0001 << bidx);
        check($sformatf("an digit %0d", bidx), an, an_exp);
        check($sformatf("frame_done digit %0d", bidx), frame_done, bidx == 2'd0);
        if (bidx == 2'd0) begin
            @(negedge clk);
            check("frame_done one cycle", frame_done, 1'b0);
        end
    endtask

    task automatic step();
        do_tick(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic advance_to(input logic [1:0] target);
        for (int k = 0; k < 4 && bidx != target; k++) step();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        advance_to(2'd3);
        do_load(v.value, v.dp_in, v.blz);
        for (int d = 0; d < 4; d++) begin
            step();
            check($sformatf("%s seg d%0d", tag, d), seg, v.seg_exp[7*d +: 7]);
            check($sformatf("%s dp d%0d", tag, d), dp, v.dp_exp[d]);
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h0042, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h89AB, 4'b0101, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1010};
        vecs[4] = '{16'hCDEF, 4'b1000, 1'b1, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b0111};
        vecs[5] = '{16'h0567, 4'b1100, 1'b1, {7'h7F, 7'h12, 7'h02, 7'h78}, 4'b0011};
        vecs[6] = '{16'h0100, 4'b0000, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b1111};

        rst = 1'b1; scan_clk = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;

        // Reset released with scan_clk already high: no tick, display stays dark.
        repeat (3) @(negedge clk);
        check_off("in reset");
        rst = 1'b0;
        @(negedge clk);
        check_off("after reset");
        repeat (3) @(negedge clk);
        check_off("scan held high");
        scan_clk = 1'b0;
        step();
        check("first tick seg", seg, 7'h40);
        check("first tick dp", dp, 1'b1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Mid-frame load: digits 2 and 3 keep the old frame.
        advance_to(2'd3);
        do_load(16'hAAAA, 4'h0, 1'b0);
        step();
        check("AAAA d0", seg, 7'h08);
        step();
        do_load(16'hFFFF, 4'h0, 1'b0);
        step();
        check("mid load d2 old", seg, 7'h08);
        step();
        check("mid load d3 old", seg, 7'h08);
        step();
        check("mid load d0 new", seg, 7'h0E);
        do_load(16'h1111, 4'h0, 1'b0);
        step();
        do_load(16'h2222, 4'h0, 1'b0);
        advance_to(2'd0);
        check("last load wins", seg, 7'h24);

        // Load in the exact wrap-tick cycle bypasses pend (which still holds 0x2222).
        advance_to(2'd3);
        do_tick(1'b1, 16'h5A5A, 4'h0, 1'b0);
        check("bypass d0", seg, 7'h08);
        step();
        check("bypass d1", seg, 7'h12);

        // Reset at idx 2 together with a tick and a load.
        advance_to(2'd2);
        @(negedge clk);
        rst = 1'b1; scan_clk = 1'b1; load = 1'b1; value = 16'h9999;
        @(negedge clk);
        rst = 1'b0; scan_clk = 1'b0; load = 1'b0;
        bidx = 2'd0;
        check_off("mid reset");
        @(negedge clk);
        check_off("mid reset released");
        step();
        check("post reset shadow d1", seg, 7'h40);
        advance_to(2'd0);
        check("post reset pend d0", seg, 7'h40);
        run_vec(vecs[0], "post reset vec0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
